// File: rtl/alu_result_fifo.sv
// alu_result_fifo: filters ALU {opcode, result} pairs and buffers them in a first-word fall-through FIFO
module alu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [7:0]    in_opcode_i,
    input  logic [7:0]    in_result_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [7:0]    out_opcode_o,
    output logic [7:0]    out_result_o,
    output logic          out_zero_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [7:0]    drop_cnt_o
);
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic          op_ok, push, pop, drop;

    // Only opcodes 1..7 are real ALU results; idle (0) and hold (8+) never reach storage.
    assign op_ok        = (in_opcode_i[7:3] == 5'd0) && (in_opcode_i[2:0] != 3'd0);
    assign full_o       = count_q == (AW+1)'(DEPTH);
    assign empty_o      = count_q == '0;
    assign push         = in_valid_i && op_ok && !full_o;
    assign drop         = in_valid_i && op_ok && full_o;
    assign pop          = !empty_o && out_ready_i;
    assign in_ready_o   = !full_o;
    assign out_valid_o  = !empty_o;
    assign out_opcode_o = mem_q[rd_ptr_q][15:8];
    assign out_result_o = mem_q[rd_ptr_q][7:0];
    assign out_zero_o   = !empty_o && (mem_q[rd_ptr_q][7:0] == 8'h00);
    assign count_o      = count_q;
    assign drop_cnt_o   = drop_q;

    // Next-state for pointers (power-of-two depth wraps naturally), occupancy and saturating drop counter.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    // Control state; reset discards all entries at once without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_opcode_i, in_result_i};
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard-based self-checking bench for alu_result_fifo
module tb_alu_result_fifo;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_opcode_i = '0;
    logic [7:0]  in_result_i = '0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  out_opcode_o;
    logic [7:0]  out_result_o;
    logic        out_zero_o;
    logic [AW:0] count_o;
    logic        full_o;
    logic        empty_o;
    logic [7:0]  drop_cnt_o;

    int tests = 0;
    int errors = 0;
    logic [15:0] sb[$];
    int drops_m = 0;

    alu_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_opcode_i(in_opcode_i), .in_result_i(in_result_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_opcode_o(out_opcode_o), .out_result_o(out_result_o), .out_zero_o(out_zero_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: the model decides push/pop/drop, popped heads are checked against the scoreboard.
    task automatic step(input logic v, input logic [7:0] op, input logic [7:0] res, input logic rdy);
        logic ok, do_push, do_pop, do_drop;
        logic [15:0] exp;
        @(negedge clk);
        in_valid_i  = v;
        in_opcode_i = op;
        in_result_i = res;
        out_ready_i = rdy;
        ok      = (op >= 8'd1) && (op <= 8'd7);
        do_pop  = (sb.size() > 0) && rdy;
        do_push = v && ok && (sb.size() < DEPTH);
        do_drop = v && ok && (sb.size() == DEPTH);
        #1;
        if (do_pop) begin
            exp = sb.pop_front();
            tests++;
            if (out_valid_o !== 1'b1 || {out_opcode_o, out_result_o} !== exp) begin
                errors++;
                $display("FAIL pop_data: got valid=%b op=%h res=%h, expected valid=1 op=%h res=%h",
                         out_valid_o, out_opcode_o, out_result_o, exp[15:8], exp[7:0]);
            end
        end
        if (do_push) sb.push_back({op, res});
        if (do_drop && drops_m < 255) drops_m++;
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({empty_o, full_o, out_valid_o, in_ready_o, out_zero_o} !== 5'b10010 || count_o !== '0 || drop_cnt_o !== 8'h00) begin
            errors++;
            $display("FAIL reset: got empty=%b full=%b ov=%b ir=%b oz=%b count=%0d drop=%0d, expected 1 0 0 1 0 0 0",
                     empty_o, full_o, out_valid_o, in_ready_o, out_zero_o, count_o, drop_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        drops_m = 0;
    endtask

    task automatic test_single();
        step(1'b1, 8'd1, 8'hED, 1'b0);
        tests++;
        if (out_valid_o !== 1'b1 || out_opcode_o !== 8'd1 || out_result_o !== 8'hED || out_zero_o !== 1'b0) begin
            errors++;
            $display("FAIL single_head: got ov=%b op=%h res=%h oz=%b, expected 1 01 ed 0",
                     out_valid_o, out_opcode_o, out_result_o, out_zero_o);
        end
        step(1'b0, 8'd0, 8'h00, 1'b1);
        tests++;
        if (empty_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: got empty=%b ov=%b, expected 1 0", empty_o, out_valid_o);
        end
    endtask

    task automatic test_filter();
        step(1'b1, 8'd0, 8'h55, 1'b0);
        step(1'b1, 8'd8, 8'h55, 1'b0);
        step(1'b1, 8'hFF, 8'h55, 1'b0);
        tests++;
        if (count_o !== '0 || drop_cnt_o !== 8'h00 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL filter: got count=%0d drop=%0d ov=%b, expected 0 0 0", count_o, drop_cnt_o, out_valid_o);
        end
    endtask

    task automatic test_full_drop();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(1 + (i % 7)), 8'(i), 1'b0);
        tests++;
        if (full_o !== 1'b1 || in_ready_o !== 1'b0 || count_o !== 4'(DEPTH) || empty_o !== 1'b0) begin
            errors++;
            $display("FAIL full: got full=%b ir=%b count=%0d empty=%b, expected 1 0 8 0", full_o, in_ready_o, count_o, empty_o);
        end
        step(1'b1, 8'd2, 8'h09, 1'b0);
        tests++;
        if (drop_cnt_o !== 8'd1 || count_o !== 4'(DEPTH)) begin
            errors++;
            $display("FAIL drop_one: got drop=%0d count=%0d, expected 1 8", drop_cnt_o, count_o);
        end
        // Pop while full does not make room for the same-cycle write.
        step(1'b1, 8'd3, 8'hAA, 1'b1);
        tests++;
        if (drop_cnt_o !== 8'(drops_m) || drops_m != 2 || count_o !== 4'(DEPTH - 1)) begin
            errors++;
            $display("FAIL no_bypass: got drop=%0d count=%0d, expected 2 7", drop_cnt_o, count_o);
        end
        while (sb.size() > 0) step(1'b0, 8'd0, 8'h00, 1'b1);
        tests++;
        if (empty_o !== 1'b1 || count_o !== '0) begin
            errors++;
            $display("FAIL drain: got empty=%b count=%0d, expected 1 0", empty_o, count_o);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 8'd4, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(1 + (i % 7)), 8'(8'h40 + i), 1'b1);
            if (count_o !== 4'(DEPTH / 2)) bad++;
        end
        tests++;
        if (bad != 0 || sb.size() != DEPTH / 2) begin
            errors++;
            $display("FAIL back_to_back: got %0d cycles with count!=4 final=%0d, expected 0 cycles and count 4", bad, count_o);
        end
        while (sb.size() > 0) step(1'b0, 8'd0, 8'h00, 1'b1);
    endtask

    task automatic test_zero_saturate();
        step(1'b1, 8'd3, 8'h00, 1'b0);
        tests++;
        if (out_zero_o !== 1'b1 || out_opcode_o !== 8'd3) begin
            errors++;
            $display("FAIL zero_head: got oz=%b op=%h, expected 1 03", out_zero_o, out_opcode_o);
        end
        for (int i = 1; i < DEPTH; i++) step(1'b1, 8'd7, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'd5, 8'h11, 1'b0);
        tests++;
        if (drop_cnt_o !== 8'hFF || drops_m != 255) begin
            errors++;
            $display("FAIL drop_sat: got drop=%0d, expected 255", drop_cnt_o);
        end
        while (sb.size() > 0) step(1'b0, 8'd0, 8'h00, 1'b1);
        tests++;
        if (out_zero_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_qual: got oz=%b ov=%b when empty, expected 0 0", out_zero_o, out_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 8'd6, 8'(8'h80 + i), 1'b0);
        tests++;
        if (count_o !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d, expected 5", count_o);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (empty_o !== 1'b1 || count_o !== '0 || drop_cnt_o !== 8'h00 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got empty=%b count=%0d drop=%0d ov=%b, expected 1 0 0 0",
                     empty_o, count_o, drop_cnt_o, out_valid_o);
        end
        sb.delete();
        drops_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'd5, 8'h77, 1'b0);
        tests++;
        if (count_o !== 4'd1 || out_opcode_o !== 8'd5 || out_result_o !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_push: got count=%0d op=%h res=%h, expected 1 05 77", count_o, out_opcode_o, out_result_o);
        end
        step(1'b0, 8'd0, 8'h00, 1'b1);
        tests++;
        if (empty_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_drain: got empty=%b, expected 1", empty_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_filter();
        test_full_drop();
        test_back_to_back();
        test_zero_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
